// File: rtl/floo_test_node_ctrl.sv
// Completion and monitor controller for multi-channel NoC test nodes.
// Counts beats and latches per-channel done, then drains, stops, or times out.
module floo_test_node_ctrl #(
  parameter int unsigned NumChannels    = 2,
  parameter int unsigned CntWidth       = 32,
  parameter int unsigned DrainCycles    = 1000,
  parameter int unsigned WatchdogCycles = 100000
) (
  input  logic                            clk_i,
  input  logic                            rst_i,
  input  logic                            en_i,
  input  logic [NumChannels-1:0]          ch_valid_i,
  input  logic [NumChannels-1:0]          ch_ready_i,
  input  logic [NumChannels-1:0]          ch_done_i,
  output logic [NumChannels*CntWidth-1:0] beat_cnt_o,
  output logic [CntWidth-1:0]             run_cycles_o,
  output logic                            all_done_o,
  output logic                            stop_o,
  output logic                            timeout_o,
  output logic [2:0]                      state_o
);

  localparam int unsigned DrainMax = (DrainCycles > 0) ? DrainCycles : 1;
  localparam int unsigned DrainW   = $clog2(DrainMax + 1);
  localparam int unsigned WdMax    = (WatchdogCycles > 0) ? WatchdogCycles : 1;
  localparam int unsigned WdW      = $clog2(WdMax + 1);
  localparam bit          WdEn     = (WatchdogCycles > 0);

  localparam logic [DrainW-1:0] DrainLoad = DrainW'(DrainCycles);
  localparam logic [DrainW-1:0] DrainOne  = DrainW'(1);
  localparam logic [WdW-1:0]    WdLast    = WdW'(WdMax - 1);
  localparam logic [WdW-1:0]    WdOne     = WdW'(1);
  localparam logic [CntWidth-1:0] CntOne  = CntWidth'(1);
  localparam logic [CntWidth-1:0] CntMax  = {CntWidth{1'b1}};

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_RUN     = 3'd1,
    S_DRAIN   = 3'd2,
    S_STOPPED = 3'd3,
    S_TIMEOUT = 3'd4
  } state_e;

  state_e                 r_state;
  logic [DrainW-1:0]      r_drain;
  logic [WdW-1:0]         r_wd;
  logic [NumChannels-1:0] r_done;
  logic [CntWidth-1:0]    r_run;
  logic                   r_all_done;
  logic                   r_stop;
  logic                   r_timeout;

  logic                   w_active;
  logic [NumChannels-1:0] w_beat;
  logic                   w_any_beat;
  logic [NumChannels-1:0] w_done_next;

  assign w_active    = (r_state == S_RUN) || (r_state == S_DRAIN);
  assign w_beat      = ch_valid_i & ch_ready_i;
  assign w_any_beat  = |w_beat;
  assign w_done_next = r_done | ch_done_i;

  for (genvar i = 0; i < NumChannels; i++) begin : g_ch
    logic [CntWidth-1:0] r_cnt;

    always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
        r_cnt <= '0;
      end else if (w_active && w_beat[i] && (r_cnt != CntMax)) begin
        r_cnt <= r_cnt + CntOne;
      end
    end

    assign beat_cnt_o[i*CntWidth +: CntWidth] = r_cnt;
  end

  // all_done tracks &r_done so the FSM can act on it the following cycle
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_done     <= '0;
      r_all_done <= 1'b0;
      r_run      <= '0;
    end else if (w_active) begin
      r_done     <= w_done_next;
      r_all_done <= &w_done_next;
      if (r_run != CntMax) begin
        r_run <= r_run + CntOne;
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state   <= S_IDLE;
      r_drain   <= '0;
      r_wd      <= '0;
      r_stop    <= 1'b0;
      r_timeout <= 1'b0;
    end else begin
      r_stop <= 1'b0;
      unique case (r_state)
        S_IDLE: begin
          if (en_i) begin
            r_state <= S_RUN;
            r_wd    <= '0;
          end
        end
        S_RUN: begin
          if (r_all_done) begin
            r_state <= S_DRAIN;
            r_drain <= DrainLoad;
            r_stop  <= (DrainCycles == 0);
          end else if (WdEn && !w_any_beat && (r_wd == WdLast)) begin
            r_state   <= S_TIMEOUT;
            r_timeout <= 1'b1;
          end else if (w_any_beat) begin
            r_wd <= '0;
          end else begin
            r_wd <= r_wd + WdOne;
          end
        end
        // stop is raised for the last drain cycle, the one that leaves DRAIN
        S_DRAIN: begin
          if (r_drain == '0) begin
            r_state <= S_STOPPED;
          end else begin
            r_drain <= r_drain - DrainOne;
            r_stop  <= (r_drain == DrainOne);
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign run_cycles_o = r_run;
  assign all_done_o   = r_all_done;
  assign stop_o       = r_stop;
  assign timeout_o    = r_timeout;
  assign state_o      = r_state;

endmodule

// File: tb/tb_floo_test_node_ctrl.sv
// Bench for floo_test_node_ctrl: two configurations driven in lockstep
// and compared every cycle with an event-time reference model.
module tb_floo_test_node_ctrl;

  logic        clk_i;
  logic        rst_i;
  logic        en_i;
  logic [1:0]  ch_valid_i;
  logic [1:0]  ch_ready_i;
  logic [1:0]  ch_done_i;

  logic [15:0] o0_cnt;
  logic [7:0]  o0_run;
  logic        o0_ad, o0_stop, o0_to;
  logic [2:0]  o0_state;

  logic [7:0]  o1_cnt;
  logic [3:0]  o1_run;
  logic        o1_ad, o1_stop, o1_to;
  logic [2:0]  o1_state;

  int vecs = 0;
  int errs = 0;

  floo_test_node_ctrl #(
    .NumChannels(2), .CntWidth(8), .DrainCycles(4), .WatchdogCycles(16)
  ) dut0 (
    .clk_i(clk_i), .rst_i(rst_i), .en_i(en_i),
    .ch_valid_i(ch_valid_i), .ch_ready_i(ch_ready_i), .ch_done_i(ch_done_i),
    .beat_cnt_o(o0_cnt), .run_cycles_o(o0_run), .all_done_o(o0_ad),
    .stop_o(o0_stop), .timeout_o(o0_to), .state_o(o0_state)
  );

  floo_test_node_ctrl #(
    .NumChannels(2), .CntWidth(4), .DrainCycles(0), .WatchdogCycles(0)
  ) dut1 (
    .clk_i(clk_i), .rst_i(rst_i), .en_i(en_i),
    .ch_valid_i(ch_valid_i), .ch_ready_i(ch_ready_i), .ch_done_i(ch_done_i),
    .beat_cnt_o(o1_cnt), .run_cycles_o(o1_run), .all_done_o(o1_ad),
    .stop_o(o1_stop), .timeout_o(o1_to), .state_o(o1_state)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  // reference model: absolute cycle times of phase changes
  int P_MAX [2] = '{255, 15};
  int P_DC  [2] = '{4, 0};
  int P_WD  [2] = '{16, 0};

  int m_c = 0;
  int m_trun [2];
  int m_tdrain [2];
  int m_tend [2];
  bit m_to [2];
  int m_last [2];
  int m_run [2];
  int m_cnt [2][2];
  bit m_done [2][2];

  function automatic void model_reset();
    for (int k = 0; k < 2; k++) begin
      m_trun[k] = -1; m_tdrain[k] = -1; m_tend[k] = -1;
      m_to[k] = 1'b0; m_last[k] = 0; m_run[k] = 0;
      for (int i = 0; i < 2; i++) begin
        m_cnt[k][i] = 0; m_done[k][i] = 1'b0;
      end
    end
  endfunction

  function automatic int ph(int k, int c);
    if (m_tend[k] >= 0 && c >= m_tend[k]) return m_to[k] ? 4 : 3;
    if (m_tdrain[k] >= 0 && c >= m_tdrain[k]) return 2;
    if (m_trun[k] >= 0 && c >= m_trun[k]) return 1;
    return 0;
  endfunction

  function automatic void model_step(int k, bit en, bit [1:0] v, bit [1:0] r, bit [1:0] d);
    int c = m_c;
    int p = ph(k, c);
    bit [1:0] b = v & r;
    bit all_vis = m_done[k][0] && m_done[k][1];
    if (p == 1 || p == 2) begin
      for (int i = 0; i < 2; i++) begin
        if (b[i] && m_cnt[k][i] < P_MAX[k]) m_cnt[k][i]++;
        if (d[i]) m_done[k][i] = 1'b1;
      end
      if (m_run[k] < P_MAX[k]) m_run[k]++;
    end
    if (p == 0 && en) begin
      m_trun[k] = c + 1;
      m_last[k] = c + 1;
    end else if (p == 1) begin
      if (all_vis) begin
        m_tdrain[k] = c + 1;
        m_tend[k]   = c + 2 + P_DC[k];
      end else if (P_WD[k] > 0 && b == 2'b00 && (c - m_last[k]) == P_WD[k] - 1) begin
        m_tend[k] = c + 1;
        m_to[k]   = 1'b1;
      end else if (b != 2'b00) begin
        m_last[k] = c + 1;
      end
    end
  endfunction

  function automatic logic [29:0] exp_vec(int k);
    logic [2:0] s;
    logic st, ad;
    s  = 3'(ph(k, m_c));
    st = !m_to[k] && m_tdrain[k] >= 0 && m_c == m_tend[k] - 1;
    ad = m_done[k][0] && m_done[k][1];
    return {s, st, m_to[k], ad, 8'(m_run[k]), 8'(m_cnt[k][1]), 8'(m_cnt[k][0])};
  endfunction

  function automatic logic [29:0] got_vec(int k);
    if (k == 0)
      return {o0_state, o0_stop, o0_to, o0_ad, o0_run, o0_cnt[15:8], o0_cnt[7:0]};
    return {o1_state, o1_stop, o1_to, o1_ad, 4'b0, o1_run,
            4'b0, o1_cnt[7:4], 4'b0, o1_cnt[3:0]};
  endfunction

  task automatic step(input bit en, input bit [1:0] v, input bit [1:0] r, input bit [1:0] d);
    en_i = en; ch_valid_i = v; ch_ready_i = r; ch_done_i = d;
    model_step(0, en, v, r, d);
    model_step(1, en, v, r, d);
    m_c++;
    @(posedge clk_i); #1;
  endtask

  task automatic do_reset();
    rst_i = 1'b1; en_i = 1'b0;
    ch_valid_i = '0; ch_ready_i = '0; ch_done_i = '0;
    model_reset();
    @(posedge clk_i); #1;
    rst_i = 1'b0;
  endtask

  task automatic test_reset();
    rst_i = 1'b1;
    model_reset();
    for (int j = 0; j < 3; j++) begin
      en_i = 1'b1;
      ch_valid_i = 2'($urandom); ch_ready_i = 2'($urandom); ch_done_i = 2'($urandom);
      @(posedge clk_i); #1;
      for (int k = 0; k < 2; k++) begin
        vecs++;
        if (got_vec(k) !== 30'd0 || got_vec(k) !== exp_vec(k)) begin
          errs++;
          $display("FAIL reset dut%0d got %h exp %h", k, got_vec(k), exp_vec(k));
        end
      end
    end
    rst_i = 1'b0; en_i = 1'b0;
  endtask

  task automatic test_basic();
    int r0 = 10, r1 = 7, gap = 0;
    bit [1:0] b, v, r;
    do_reset();
    step(1'b1, 2'($urandom), 2'($urandom), 2'b00);
    while (r0 > 0 || r1 > 0) begin
      b = 2'b00;
      if (r0 > 0 && ($urandom_range(1) == 1 || gap > 8)) begin b[0] = 1'b1; r0--; end
      if (r1 > 0 && ($urandom_range(1) == 1 || gap > 8)) begin b[1] = 1'b1; r1--; end
      gap = (b != 2'b00) ? 0 : gap + 1;
      v = b | (2'($urandom) & ~b);
      r = b | (2'($urandom) & ~v);
      step(1'($urandom), v, r, 2'b00);
      for (int k = 0; k < 2; k++) begin
        vecs++;
        if (got_vec(k) !== exp_vec(k)) begin
          errs++;
          $display("FAIL basic dut%0d cyc %0d got %h exp %h", k, m_c, got_vec(k), exp_vec(k));
        end
      end
    end
    step(1'($urandom), 2'b00, 2'b00, 2'b11);
    vecs++;
    if (o0_ad !== 1'b1 || o0_cnt !== {8'd7, 8'd10}) begin
      errs++;
      $display("FAIL basic_counts got ad=%b cnt=%h exp ad=1 cnt=070a", o0_ad, o0_cnt);
    end
    for (int j = 1; j <= 6; j++) begin
      step(1'b0, 2'b00, 2'b00, 2'b00);
      for (int k = 0; k < 2; k++) begin
        vecs++;
        if (got_vec(k) !== exp_vec(k)) begin
          errs++;
          $display("FAIL basic_drain dut%0d cyc %0d got %h exp %h", k, m_c, got_vec(k), exp_vec(k));
        end
      end
      vecs++;
      if (o0_stop !== (j == 5)) begin
        errs++;
        $display("FAIL basic_stop j=%0d got %b exp %b", j, o0_stop, (j == 5));
      end
    end
    vecs++;
    if (o0_state !== 3'd3) begin
      errs++;
      $display("FAIL basic_state got %0d exp 3", o0_state);
    end
  endtask

  task automatic test_staggered();
    int gap = 0;
    logic [7:0] c1;
    bit [1:0] b;
    do_reset();
    step(1'b1, 2'b00, 2'b00, 2'b00);
    for (int cy = 0; cy <= 50; cy++) begin
      b = 2'b00;
      if ($urandom_range(3) != 0 || gap > 6) b[1] = 1'b1;
      if (cy < 20 && $urandom_range(1) == 1) b[0] = 1'b1;
      gap = (b != 2'b00) ? 0 : gap + 1;
      step(1'($urandom), b, b, {cy == 50, cy == 20});
      for (int k = 0; k < 2; k++) begin
        vecs++;
        if (got_vec(k) !== exp_vec(k)) begin
          errs++;
          $display("FAIL stag dut%0d cyc %0d got %h exp %h", k, m_c, got_vec(k), exp_vec(k));
        end
      end
      vecs++;
      if (o0_state !== 3'd1) begin
        errs++;
        $display("FAIL stag_run cy=%0d got %0d exp 1", cy, o0_state);
      end
    end
    c1 = o0_cnt[15:8];
    for (int j = 0; j < 8; j++) begin
      step(1'b0, 2'b10, 2'b10, 2'b00);
      for (int k = 0; k < 2; k++) begin
        vecs++;
        if (got_vec(k) !== exp_vec(k)) begin
          errs++;
          $display("FAIL stag_drain dut%0d cyc %0d got %h exp %h", k, m_c, got_vec(k), exp_vec(k));
        end
      end
    end
    vecs++;
    if (o0_state !== 3'd3 || o0_cnt[15:8] !== 8'(c1 + 8'd6)) begin
      errs++;
      $display("FAIL stag_final got st=%0d c1=%0d exp st=3 c1=%0d", o0_state, o0_cnt[15:8], c1 + 8'd6);
    end
  endtask

  task automatic test_watchdog();
    do_reset();
    step(1'b1, 2'b00, 2'b00, 2'b00);
    for (int j = 0; j < 16; j++) begin
      step(1'b0, 2'b00, 2'b00, 2'b00);
      for (int k = 0; k < 2; k++) begin
        vecs++;
        if (got_vec(k) !== exp_vec(k)) begin
          errs++;
          $display("FAIL wd dut%0d cyc %0d got %h exp %h", k, m_c, got_vec(k), exp_vec(k));
        end
      end
      vecs++;
      if (o0_to !== (j == 15)) begin
        errs++;
        $display("FAIL wd_flag j=%0d got %b exp %b", j, o0_to, (j == 15));
      end
    end
    for (int j = 0; j < 6; j++) begin
      step(1'($urandom), 2'($urandom), 2'($urandom), 2'($urandom));
      vecs++;
      if (o0_state !== 3'd4 || o0_to !== 1'b1 || o0_stop !== 1'b0) begin
        errs++;
        $display("FAIL wd_sticky got st=%0d to=%b stop=%b exp st=4 to=1 stop=0", o0_state, o0_to, o0_stop);
      end
    end
    do_reset();
    step(1'b1, 2'b00, 2'b00, 2'b00);
    for (int j = 0; j < 32; j++) begin
      step(1'b0, (j == 15) ? 2'b01 : 2'b00, 2'b11, 2'b00);
      for (int k = 0; k < 2; k++) begin
        vecs++;
        if (got_vec(k) !== exp_vec(k)) begin
          errs++;
          $display("FAIL wd_restart dut%0d cyc %0d got %h exp %h", k, m_c, got_vec(k), exp_vec(k));
        end
      end
      vecs++;
      if (o0_to !== (j == 31)) begin
        errs++;
        $display("FAIL wd_window j=%0d got %b exp %b", j, o0_to, (j == 31));
      end
    end
  endtask

  task automatic test_saturation();
    do_reset();
    step(1'b1, 2'b00, 2'b00, 2'b00);
    for (int j = 0; j < 20; j++) begin
      step(1'($urandom), 2'b01, 2'b01, 2'b00);
      for (int k = 0; k < 2; k++) begin
        vecs++;
        if (got_vec(k) !== exp_vec(k)) begin
          errs++;
          $display("FAIL sat dut%0d cyc %0d got %h exp %h", k, m_c, got_vec(k), exp_vec(k));
        end
      end
    end
    vecs++;
    if (o1_cnt[3:0] !== 4'd15 || o1_run !== 4'd15 || o0_cnt[7:0] !== 8'd20) begin
      errs++;
      $display("FAIL sat_final got c1=%0d r1=%0d c0=%0d exp 15 15 20", o1_cnt[3:0], o1_run, o0_cnt[7:0]);
    end
  endtask

  task automatic test_reset_mid_drain();
    int n = 0;
    bit [1:0] b;
    do_reset();
    step(1'b1, 2'b00, 2'b00, 2'b00);
    step(1'b0, 2'b11, 2'b11, 2'b11);
    step(1'b0, 2'b01, 2'b01, 2'b00);
    step(1'b0, 2'b10, 2'b10, 2'b00);
    for (int k = 0; k < 2; k++) begin
      vecs++;
      if (got_vec(k) !== exp_vec(k)) begin
        errs++;
        $display("FAIL mid_pre dut%0d got %h exp %h", k, got_vec(k), exp_vec(k));
      end
    end
    vecs++;
    if (o0_state !== 3'd2) begin
      errs++;
      $display("FAIL mid_in_drain got %0d exp 2", o0_state);
    end
    #3;
    rst_i = 1'b1;
    #1;
    model_reset();
    for (int k = 0; k < 2; k++) begin
      vecs++;
      if (got_vec(k) !== 30'd0) begin
        errs++;
        $display("FAIL mid_async dut%0d got %h exp 0", k, got_vec(k));
      end
    end
    @(posedge clk_i); #1;
    rst_i = 1'b0;
    step(1'b1, 2'b00, 2'b00, 2'b00);
    while (n < 3) begin
      b = 2'($urandom_range(1));
      n += b[0];
      step(1'b0, b, b, 2'b00);
      for (int k = 0; k < 2; k++) begin
        vecs++;
        if (got_vec(k) !== exp_vec(k)) begin
          errs++;
          $display("FAIL mid_fresh dut%0d cyc %0d got %h exp %h", k, m_c, got_vec(k), exp_vec(k));
        end
      end
    end
    vecs++;
    if (o0_cnt !== 16'd3 || o0_state !== 3'd1) begin
      errs++;
      $display("FAIL mid_restart got cnt=%h st=%0d exp cnt=0003 st=1", o0_cnt, o0_state);
    end
  endtask

  task automatic test_drain_zero();
    logic [2:0] est [4] = '{3'd1, 3'd1, 3'd2, 3'd3};
    bit         estp [4] = '{1'b0, 1'b0, 1'b1, 1'b0};
    do_reset();
    for (int j = 0; j < 4; j++) begin
      step(j == 0, 2'b00, 2'b00, (j < 2) ? 2'b11 : 2'b00);
      for (int k = 0; k < 2; k++) begin
        vecs++;
        if (got_vec(k) !== exp_vec(k)) begin
          errs++;
          $display("FAIL dz dut%0d cyc %0d got %h exp %h", k, m_c, got_vec(k), exp_vec(k));
        end
      end
      vecs++;
      if (o1_state !== est[j] || o1_stop !== estp[j]) begin
        errs++;
        $display("FAIL dz_seq j=%0d got st=%0d stop=%b exp st=%0d stop=%b",
                 j, o1_state, o1_stop, est[j], estp[j]);
      end
    end
  endtask

  task automatic test_random();
    bit [1:0] d;
    for (int run = 0; run < 4; run++) begin
      do_reset();
      for (int j = 0; j < 80; j++) begin
        d = {$urandom_range(15) == 0, $urandom_range(15) == 0};
        step($urandom_range(3) == 0, 2'($urandom), 2'($urandom), d);
        for (int k = 0; k < 2; k++) begin
          vecs++;
          if (got_vec(k) !== exp_vec(k)) begin
            errs++;
            $display("FAIL rand dut%0d cyc %0d got %h exp %h", k, m_c, got_vec(k), exp_vec(k));
          end
        end
      end
    end
  endtask

  initial begin
    rst_i = 1'b1; en_i = 1'b0;
    ch_valid_i = '0; ch_ready_i = '0; ch_done_i = '0;
    model_reset();
    #1;
    test_reset();
    test_basic();
    test_staggered();
    test_watchdog();
    test_saturation();
    test_reset_mid_drain();
    test_drain_zero();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
